// File: rtl/seven_segment_scan_controller.sv
// rtl/seven_segment_scan_controller.sv - time-multiplexed 4-digit seven-segment scan controller
//
// Purpose: scans four pre-decoded seven-segment patterns onto a shared
// segment bus, one digit at a time, with an all-off dead time before each
// digit. Optional leading-zero blanking of the minute-tens digit.
//
// Ports:
//   clk              clock, all registers update on the rising edge
//   rst              synchronous active-high reset
//   enable           scanning runs while high; low forces idle
//   seg_second_unit  segment pattern, digit 0 (active-high segments)
//   seg_second_tens  segment pattern, digit 1
//   seg_minute_unit  segment pattern, digit 2
//   seg_minute_tens  segment pattern, digit 3
//   bcd_minute_tens  BCD value of digit 3, used only for blanking
//   seg_out          registered shared segment bus
//   an               registered active-low digit enables, an[i] = digit i
//   digit_idx        digit currently in its dead-time or drive slot
//   frame_done       one-cycle pulse after the last drive cycle of digit 3

module seven_segment_scan_controller #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEAD_CYCLES    = 16,
    parameter int BLANK_LEAD     = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [6:0] seg_second_unit,
    input  logic [6:0] seg_second_tens,
    input  logic [6:0] seg_minute_unit,
    input  logic [6:0] seg_minute_tens,
    input  logic [3:0] bcd_minute_tens,
    output logic [6:0] seg_out,
    output logic [3:0] an,
    output logic [1:0] digit_idx,
    output logic       frame_done
);

    localparam int MAXV = (SCAN_DIV > DEAD_CYCLES) ? SCAN_DIV : DEAD_CYCLES;
    localparam int CW   = (MAXV > 1) ? $clog2(MAXV + 1) : 1;

    localparam logic [CW-1:0] SCAN_LOAD = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_LOAD = (DEAD_CYCLES > 0) ? CW'(DEAD_CYCLES - 1) : '0;
    localparam bit            HAS_DEAD  = (DEAD_CYCLES > 0);
    localparam bit            LEAD_EN   = (BLANK_LEAD != 0);
    localparam logic [6:0]    SEG_INV   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [6:0]    SEG_OFF   = SEG_INV;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_q, frame_d;

    logic          enter_drive;
    logic [1:0]    drive_idx;
    logic [6:0]    drive_pat;
    logic          drive_blank;

    // Pattern for the digit about to be driven; only consumed on the
    // DRIVE-entry edge, so later input changes cannot tear the slot.
    always_comb begin
        drive_pat = seg_second_unit;
        case (drive_idx)
            2'd0:    drive_pat = seg_second_unit;
            2'd1:    drive_pat = seg_second_tens;
            2'd2:    drive_pat = seg_minute_unit;
            default: drive_pat = seg_minute_tens;
        endcase
    end

    assign drive_blank = LEAD_EN && (drive_idx == 2'd3) && (bcd_minute_tens == 4'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        an_d        = an_q;
        seg_d       = seg_q;
        frame_d     = 1'b0;
        enter_drive = 1'b0;
        drive_idx   = idx_q;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = 2'd0;
            an_d    = 4'b1111;
            seg_d   = SEG_OFF;
        end else begin
            case (state_q)
                IDLE: begin
                    if (HAS_DEAD) begin
                        state_d = BLANK;
                        cnt_d   = DEAD_LOAD;
                        idx_d   = 2'd0;
                        an_d    = 4'b1111;
                        seg_d   = SEG_OFF;
                    end else begin
                        enter_drive = 1'b1;
                        drive_idx   = 2'd0;
                    end
                end
                BLANK: begin
                    if (cnt_q == '0) begin
                        enter_drive = 1'b1;
                        drive_idx   = idx_q;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                DRIVE: begin
                    if (cnt_q == '0) begin
                        frame_d = (idx_q == 2'd3);
                        if (HAS_DEAD) begin
                            state_d = BLANK;
                            cnt_d   = DEAD_LOAD;
                            idx_d   = idx_q + 2'd1;
                            an_d    = 4'b1111;
                            seg_d   = SEG_OFF;
                        end else begin
                            enter_drive = 1'b1;
                            drive_idx   = idx_q + 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    an_d    = 4'b1111;
                    seg_d   = SEG_OFF;
                end
            endcase

            // Shared DRIVE-entry path: reload counter, latch pattern, select anode.
            if (enter_drive) begin
                state_d = DRIVE;
                cnt_d   = SCAN_LOAD;
                idx_d   = drive_idx;
                if (drive_blank) begin
                    an_d  = 4'b1111;
                    seg_d = SEG_OFF;
                end else begin
                    an_d  = ~(4'b0001 << drive_idx);
                    seg_d = drive_pat ^ SEG_INV;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_OFF;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
        end
    end

    assign seg_out    = seg_q;
    assign an         = an_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_q;

endmodule

// File: doc/seven_segment_scan_controller.md
SEVEN_SEGMENT_SCAN_CONTROLLER -- requirements
Module: seven_segment_scan_controller

Interface
REQ-001 Parameter SCAN_DIV, default 50000, SHALL set the number of clock cycles each digit is driven (legal range 1 to 2^20-1).
REQ-002 Parameter DEAD_CYCLES, default 16, SHALL set the number of all-anodes-off cycles inserted before each digit (legal range 0 to 255).
REQ-003 Parameter BLANK_LEAD, default 1, SHALL enable (1) or disable (0) leading-zero blanking of the minute-tens digit.
REQ-004 Parameter SEG_ACTIVE_LOW, default 0, SHALL invert seg_out when set to 1; inputs are always active-high segment patterns.
REQ-005 Port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port enable, input, 1 bit: scanning runs while high.
REQ-008 Ports seg_second_unit, seg_second_tens, seg_minute_unit, seg_minute_tens, inputs, 7 bits each: decoded patterns for digits 0 to 3 respectively.
REQ-009 Port bcd_minute_tens, input, 4 bits: BCD value of digit 3, used only for blanking.
REQ-010 Port seg_out, output, 7 bits: shared segment bus, registered.
REQ-011 Port an, output, 4 bits: active-low digit enables, with an[i] selecting digit i; registered.
REQ-012 Port digit_idx, output, 2 bits: index of the digit currently in its BLANK or DRIVE slot.
REQ-013 Port frame_done, output, 1 bit: one-cycle pulse at the end of each complete 4-digit frame.

Function
REQ-014 The FSM SHALL have states IDLE, BLANK and DRIVE.
REQ-015 IDLE behaviour:
- an = 4'b1111, seg_out = OFF, digit_idx = 0.
- Transition on an edge that samples enable = 1: to BLANK if DEAD_CYCLES > 0, otherwise directly to DRIVE.
REQ-016 BLANK behaviour:
- an = 4'b1111, seg_out = OFF.
- Lasts exactly DEAD_CYCLES cycles, then moves to DRIVE.
REQ-017 DRIVE behaviour:
- an drives the bit for digit_idx low and all other bits high.
- seg_out holds the selected input pattern, captured on the edge that enters DRIVE and held constant for the whole slot (no mid-slot tearing).
- Lasts exactly SCAN_DIV cycles.
REQ-018 At the end of DRIVE:
- digit_idx increments modulo 4 (3 wraps to 0).
- The FSM moves to BLANK, or to DRIVE if DEAD_CYCLES = 0.
REQ-019 Frame period SHALL be exactly 4*(SCAN_DIV+DEAD_CYCLES) cycles.
REQ-020 frame_done SHALL be 1 for exactly one cycle, the cycle after the last DRIVE cycle of digit 3.
REQ-021 OFF SHALL be 7'h00 when SEG_ACTIVE_LOW = 0 and 7'h7F when SEG_ACTIVE_LOW = 1.
REQ-022 Leading-zero blanking: when BLANK_LEAD = 1 and bcd_minute_tens sampled at DRIVE entry for digit 3 equals 0:
- an stays 4'b1111 and seg_out stays OFF for that slot.
- Slot timing and frame_done are unchanged.
REQ-023 A single down-counter SHALL time both BLANK and DRIVE.
- Its width SHALL cover max(SCAN_DIV, DEAD_CYCLES).
- It SHALL reload on every state entry.
REQ-024 enable deasserted in any state SHALL force IDLE on the next edge (outputs off, digit_idx = 0, no frame_done).
- Re-enabling always starts at digit 0.
REQ-025 Input pattern changes outside the DRIVE-entry edge SHALL NOT affect seg_out until the next slot.

Reset
REQ-026 While rst is sampled high, on the next edge the block SHALL enter IDLE with:
- an = 4'b1111, seg_out = OFF, digit_idx = 0, frame_done = 0, counter = 0.
- rst SHALL take priority over enable.
REQ-027 rst asserted mid-DRIVE or mid-BLANK SHALL abort the slot immediately, and no frame_done SHALL be produced.

Verification
REQ-028 Basic scan (SCAN_DIV=4, DEAD_CYCLES=1, inputs 7'h06/7'h5B/7'h4F/7'h66, bcd_minute_tens=4, enable rising):
- an = 4'b1110 with seg_out = 7'h06 appears 2 edges after enable is sampled.
- an sequence, each 4 cycles with a 1-cycle 4'b1111 gap: 1110, 1101, 1011, 0111.
- frame_done fires every 20 cycles.
REQ-029 Leading-zero blanking (bcd_minute_tens=0, BLANK_LEAD=1): the digit-3 slot shows an = 4'b1111 and seg_out = 7'h00, and the period stays at 20 cycles; with BLANK_LEAD=0, an = 4'b0111 is driven.
REQ-030 DEAD_CYCLES=0, SCAN_DIV=1: an rotates every cycle with no gap, and frame_done pulses every 4 cycles.
REQ-031 Mid-slot input change: change seg_second_unit during the digit-0 DRIVE slot; seg_out holds the old value until the next digit-0 slot.
REQ-032 Abort and restart:
- enable dropped during digit 2: IDLE on the next edge, an = 4'b1111.
- Re-enable: scanning restarts at digit 0.
- rst during DRIVE: all outputs reach reset values after one edge.
REQ-033 SEG_ACTIVE_LOW=1: OFF = 7'h7F, and digit 0 with input 7'h06 gives seg_out = 7'h79.
